// File: rtl/ltssm_pkg.sv
// Shared encodings for the LTSSM timeout sequencer.
// LPIF request/status codes, Tx/Rx substates, FSM states and timeout limits.
package ltssm_pkg;

    localparam logic [3:0] LPIF_RESET   = 4'd0;
    localparam logic [3:0] LPIF_ACTIVE  = 4'd1;
    localparam logic [3:0] LPIF_RETRAIN = 4'd2;

    localparam logic [3:0] SS_DETECT_QUIET  = 4'd0;
    localparam logic [3:0] SS_DETECT_ACTIVE = 4'd1;
    localparam logic [3:0] SS_POLL_ACTIVE   = 4'd2;
    localparam logic [3:0] SS_POLL_CONFIG   = 4'd3;
    localparam logic [3:0] SS_CFG_LW_START  = 4'd4;
    localparam logic [3:0] SS_CFG_LW_ACCEPT = 4'd5;
    localparam logic [3:0] SS_CFG_LN_WAIT   = 4'd6;
    localparam logic [3:0] SS_CFG_LN_ACCEPT = 4'd7;
    localparam logic [3:0] SS_CFG_COMPLETE  = 4'd8;
    localparam logic [3:0] SS_CFG_IDLE      = 4'd9;
    localparam logic [3:0] SS_L0            = 4'd10;

    localparam logic [5:0] MS_SAT = 6'd63;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRAIN,
        ST_FORCE,
        ST_LINKED,
        ST_ACTIVE,
        ST_FAIL
    } seq_state_e;

    // Zero means the substate has no timeout.
    function automatic logic [5:0] timeoutLimitMs(input logic [3:0] substate);
        logic [5:0] lim;
        case (substate)
            SS_DETECT_QUIET,
            SS_DETECT_ACTIVE: lim = 6'd12;
            SS_POLL_ACTIVE:   lim = 6'd24;
            SS_POLL_CONFIG:   lim = 6'd48;
            SS_CFG_LW_START:  lim = 6'd24;
            SS_CFG_LW_ACCEPT,
            SS_CFG_LN_WAIT,
            SS_CFG_LN_ACCEPT,
            SS_CFG_COMPLETE,
            SS_CFG_IDLE:      lim = 6'd2;
            default:          lim = 6'd0;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/ltssm_ms_timer.sv
// Millisecond timer: prescaler wraps every TICK_DIV clocks.
// tick and msCount are registered together, so msCount is fresh when tick is high.
module ltssm_ms_timer
    import ltssm_pkg::*;
#(
    parameter int unsigned TICK_DIV = 125000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       enable_i,
    output logic       tick_o,
    output logic [5:0] msCount_o
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [5:0]    ms_q, ms_d;
    logic          tick_q, tick_d;

    // Next-state: clear dominates, otherwise count while enabled.
    always_comb begin
        pre_d  = pre_q;
        ms_d   = ms_q;
        tick_d = 1'b0;
        if (clear_i) begin
            pre_d = '0;
            ms_d  = '0;
        end else if (enable_i) begin
            if (pre_q == PRE_LAST) begin
                pre_d  = '0;
                tick_d = 1'b1;
                if (ms_q != MS_SAT) begin
                    ms_d = ms_q + 6'd1;
                end
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    // Timer state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q  <= '0;
            ms_q   <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            ms_q   <= ms_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o    = tick_q;
    assign msCount_o = ms_q;

endmodule

// File: rtl/ltssm_timeout_sequencer.sv
// Supervises mainLTSSM substate timeouts, forces detect on expiry,
// counts failed training attempts and gates LPIF state requests.
module ltssm_timeout_sequencer
    import ltssm_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 125000,
    parameter int unsigned MAX_RETRIES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] lpReqIn,
    input  logic [3:0] lpifStateStatus,
    input  logic [3:0] substateTx,
    input  logic [3:0] substateRx,
    input  logic       linkUp,
    output logic [3:0] lpifStateRequest,
    output logic       forceDetect,
    output logic       quietDone,
    output logic [3:0] timeoutState,
    output logic [2:0] retryCount,
    output logic       linkFail
);

    seq_state_e state_q;
    logic [7:0] sub_q;
    logic [3:0] req_q;
    logic       force_q;
    logic       quiet_q;
    logic [3:0] tstate_q;
    logic [2:0] retry_q;
    logic       fail_q;

    logic       change;
    logic       tick;
    logic [5:0] msCount;
    logic [5:0] limit;
    logic       expire;
    logic       retry_max;
    logic [3:0] req_gate;

    assign change    = {substateTx, substateRx} != sub_q;
    assign limit     = timeoutLimitMs(substateTx);
    assign expire    = tick && (limit != 6'd0) && (msCount == limit)
                       && !change && (state_q == ST_TRAIN);
    assign retry_max = retry_q == 3'(MAX_RETRIES);

    ltssm_ms_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (change || (state_q != ST_TRAIN)),
        .enable_i  (state_q == ST_TRAIN),
        .tick_o    (tick),
        .msCount_o (msCount)
    );

    // Which link-layer request may pass in the current state.
    always_comb begin
        req_gate = LPIF_RESET;
        unique case (1'b1)
            (lpReqIn == LPIF_ACTIVE)
                && ((state_q == ST_LINKED) || (state_q == ST_ACTIVE)):
                req_gate = LPIF_ACTIVE;
            (lpReqIn == LPIF_RETRAIN) && (lpifStateStatus == LPIF_ACTIVE):
                req_gate = LPIF_RETRAIN;
            default:
                req_gate = LPIF_RESET;
        endcase
    end

    // Supervisor FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            sub_q    <= '0;
            req_q    <= '0;
            force_q  <= 1'b0;
            quiet_q  <= 1'b0;
            tstate_q <= '0;
            retry_q  <= '0;
            fail_q   <= 1'b0;
        end else begin
            sub_q   <= {substateTx, substateRx};
            force_q <= 1'b0;
            quiet_q <= 1'b0;
            req_q   <= req_gate;
            case (state_q)
                ST_IDLE: begin
                    if ((lpifStateStatus == LPIF_RESET) && (substateTx != SS_L0)) begin
                        state_q <= ST_TRAIN;
                    end
                end
                ST_TRAIN: begin
                    if (expire && (substateTx == SS_DETECT_QUIET)) begin
                        quiet_q <= 1'b1;
                    end
                    if (retry_max) begin
                        state_q <= ST_FAIL;
                        fail_q  <= 1'b1;
                        req_q   <= '0;
                    end else if (linkUp) begin
                        state_q <= ST_LINKED;
                    end else if (expire && (substateTx != SS_DETECT_QUIET)) begin
                        state_q  <= ST_FORCE;
                        force_q  <= 1'b1;
                        req_q    <= '0;
                        tstate_q <= substateTx;
                        if (retry_q != 3'h7) begin
                            retry_q <= retry_q + 3'd1;
                        end
                    end
                end
                ST_FORCE: begin
                    state_q <= ST_TRAIN;
                    req_q   <= '0;
                end
                ST_LINKED: begin
                    if (lpifStateStatus == LPIF_ACTIVE) begin
                        state_q <= ST_ACTIVE;
                        retry_q <= '0;
                    end else if (!linkUp) begin
                        state_q <= ST_TRAIN;
                    end
                end
                ST_ACTIVE: begin
                    if (lpifStateStatus == LPIF_RESET) begin
                        state_q <= ST_TRAIN;
                    end
                end
                ST_FAIL: begin
                    req_q <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign lpifStateRequest = req_q;
    assign forceDetect      = force_q;
    assign quietDone        = quiet_q;
    assign timeoutState     = tstate_q;
    assign retryCount       = retry_q;
    assign linkFail         = fail_q;

endmodule
